// File: rtl/keypad_scanner_4x5_pkg.sv
// Shared constants, FSM state type and key index helper for the 4x5 keypad scanner.
package keypad_pkg;

  localparam logic [5:0] KEY_NONE = 6'd63;
  localparam int         ROWS     = 4;
  localparam int         COLS     = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } keypad_state_t;

  function automatic logic [5:0] key_index(input logic [1:0] row, input logic [2:0] col);
    return 6'(row) * 6'(COLS) + 6'(col);
  endfunction

endpackage

// File: rtl/keypad_scanner_4x5_if.sv
// Matrix and key-report signals of the scanner; master is the scanner, slave its environment.
// Handshake: strobe is a one-cycle pulse marking the first cycle of valid for a newly accepted key;
// coder is meaningful only while valid is high and reads KEY_NONE otherwise. No back-pressure.
interface keypad_scanner_4x5_if;
  import keypad_pkg::*;

  logic [COLS-1:0] column_in;
  logic [ROWS-1:0] row_out;
  logic [5:0]      coder;
  logic            valid;
  logic            strobe;
  keypad_state_t   state;

  modport master (input column_in, output row_out, coder, valid, strobe, state);
  modport slave  (output column_in, input row_out, coder, valid, strobe, state);

endinterface

// File: rtl/keypad_row_scanner.sv
// Drives the rows one-hot, samples columns at the end of each row dwell and reduces
// a full frame to the lowest pressed key index.
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [COLS-1:0] i_column,
  output logic [ROWS-1:0] o_row,
  output logic            o_frame_done,
  output logic [5:0]      o_frame_key
);

  localparam int DW = $clog2(SCAN_CYCLES);

  logic [DW-1:0]   r_dwell;
  logic [ROWS-1:0] r_row;
  logic [1:0]      r_row_idx;
  logic [5:0]      r_best;
  logic            r_frame_done;
  logic [5:0]      r_frame_key;
  logic            w_terminal;
  logic [5:0]      w_row_key;
  logic [5:0]      w_merged;

  assign w_terminal = (r_dwell == DW'(SCAN_CYCLES - 1));

  // Walk columns high to low so the lowest pressed column is the last assignment.
  always_comb begin
    w_row_key = KEY_NONE;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (i_column[c]) w_row_key = key_index(r_row_idx, 3'(c));
    end
  end

  assign w_merged = (w_row_key < r_best) ? w_row_key : r_best;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dwell      <= '0;
      r_row        <= ROWS'(1);
      r_row_idx    <= '0;
      r_best       <= KEY_NONE;
      r_frame_done <= 1'b0;
      r_frame_key  <= KEY_NONE;
    end else begin
      r_frame_done <= 1'b0;
      if (w_terminal) begin
        r_dwell   <= '0;
        r_row     <= {r_row[ROWS-2:0], r_row[ROWS-1]};
        r_row_idx <= r_row_idx + 2'd1;
        if (r_row_idx == 2'(ROWS - 1)) begin
          r_frame_key  <= w_merged;
          r_frame_done <= 1'b1;
          r_best       <= KEY_NONE;
        end else begin
          r_best <= w_merged;
        end
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  assign o_row        = r_row;
  assign o_frame_done = r_frame_done;
  assign o_frame_key  = r_frame_key;

endmodule

// File: rtl/keypad_scanner_4x5.sv
// 4x5 keypad scanner: row scanning plus a frame-rate debounce FSM with registered key outputs.
module keypad_scanner_4x5
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input logic                  clock,
  input logic                  reset,
  keypad_scanner_4x5_if.master bus
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic          w_frame_done;
  logic [5:0]    w_frame_key;
  keypad_state_t r_state, w_state_n;
  logic [5:0]    r_cand, w_cand_n;
  logic [5:0]    r_held, w_held_n;
  logic [CW-1:0] r_count, w_count_n;
  logic [5:0]    r_coder, w_coder_n;
  logic          r_valid, w_valid_n;
  logic          r_strobe, w_strobe_n;
  logic          w_count_hit;

  keypad_row_scanner #(.SCAN_CYCLES(SCAN_CYCLES)) u_scan (
    .clock        (clock),
    .reset        (reset),
    .i_column     (bus.column_in),
    .o_row        (bus.row_out),
    .o_frame_done (w_frame_done),
    .o_frame_key  (w_frame_key)
  );

  assign w_count_hit = (32'(r_count) + 32'd1 >= 32'(DEBOUNCE_SCANS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cand   <= KEY_NONE;
      r_held   <= KEY_NONE;
      r_count  <= '0;
      r_coder  <= KEY_NONE;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cand   <= w_cand_n;
      r_held   <= w_held_n;
      r_count  <= w_count_n;
      r_coder  <= w_coder_n;
      r_valid  <= w_valid_n;
      r_strobe <= w_strobe_n;
    end
  end

  // State only moves on the frame-end pulse; outputs follow the next state one clock later.
  always_comb begin
    w_state_n  = r_state;
    w_cand_n   = r_cand;
    w_held_n   = r_held;
    w_count_n  = r_count;
    w_strobe_n = 1'b0;
    if (w_frame_done) begin
      case (r_state)
        IDLE: begin
          if (w_frame_key != KEY_NONE) begin
            if (DEBOUNCE_SCANS <= 1) begin
              w_state_n  = PRESSED;
              w_held_n   = w_frame_key;
              w_count_n  = '0;
              w_strobe_n = 1'b1;
            end else begin
              w_state_n = DEBOUNCE;
              w_cand_n  = w_frame_key;
              w_count_n = CW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (w_frame_key == KEY_NONE) begin
            w_state_n = IDLE;
            w_count_n = '0;
          end else if (w_frame_key == r_cand) begin
            if (w_count_hit) begin
              w_state_n  = PRESSED;
              w_held_n   = r_cand;
              w_count_n  = '0;
              w_strobe_n = 1'b1;
            end else begin
              w_count_n = r_count + CW'(1);
            end
          end else begin
            w_cand_n  = w_frame_key;
            w_count_n = CW'(1);
          end
        end
        PRESSED: begin
          if (w_frame_key != r_held) begin
            w_state_n = (DEBOUNCE_SCANS <= 1) ? IDLE : RELEASE;
            w_count_n = (DEBOUNCE_SCANS <= 1) ? '0 : CW'(1);
          end
        end
        RELEASE: begin
          if (w_frame_key == r_held) begin
            w_state_n = PRESSED;
            w_count_n = '0;
          end else if (w_count_hit) begin
            w_state_n = IDLE;
            w_count_n = '0;
          end else begin
            w_count_n = r_count + CW'(1);
          end
        end
        default: begin
          w_state_n = IDLE;
          w_count_n = '0;
        end
      endcase
    end
    w_valid_n = (w_state_n == PRESSED) || (w_state_n == RELEASE);
    w_coder_n = w_valid_n ? w_held_n : KEY_NONE;
  end

  assign bus.coder  = r_coder;
  assign bus.valid  = r_valid;
  assign bus.strobe = r_strobe;
  assign bus.state  = r_state;

endmodule

// File: tb/tb_keypad_scanner_4x5.sv
// Bench for keypad_scanner_4x5: directed scenarios then random key sets, checked every clock
// against a frame-level behavioural model of scanning and debouncing.
module tb_keypad_scanner_4x5;
  import keypad_pkg::*;

  localparam int DEB   = 3;
  localparam int FRAME = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  keypad_scanner_4x5_if bus ();

  keypad_scanner_4x5 #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(DEB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Physical matrix: a pressed key connects its row line to its column line.
  logic [19:0] keys = '0;
  logic [4:0]  cols_drv;
  always_comb begin
    cols_drv = '0;
    for (int r = 0; r < 4; r++) begin
      if (bus.row_out[r]) cols_drv = cols_drv | keys[r*5 +: 5];
    end
  end
  assign bus.column_in = cols_drv;

  int checks = 0;
  int errors = 0;
  int e = 0;
  int m_held = -1, m_cand = -1, m_run = 0, m_miss = 0;
  logic exp_strobe = 1'b0;
  int pend_key = 63;
  logic pend_valid = 1'b0;
  int strobe_seen = 0;
  int accept_e = -1;
  logic prev_valid = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic int lowest_key(input logic [19:0] k);
    for (int i = 0; i < 20; i++) if (k[i]) return i;
    return 63;
  endfunction

  // Debounce rules expressed directly on frame results.
  task automatic model_frame(input int r);
    if (m_held < 0) begin
      if (r == 63) begin
        m_run = 0; m_cand = -1;
      end else if (r == m_cand) begin
        m_run++;
      end else begin
        m_cand = r; m_run = 1;
      end
      if (m_run >= DEB) begin
        m_held = m_cand; m_run = 0; m_cand = -1; m_miss = 0; exp_strobe = 1'b1;
      end
    end else begin
      if (r != m_held) m_miss++;
      else m_miss = 0;
      if (m_miss >= DEB) begin
        m_held = -1; m_miss = 0; m_run = 0; m_cand = -1;
      end
    end
  endtask

  task automatic model_reset();
    m_held = -1; m_cand = -1; m_run = 0; m_miss = 0;
    pend_valid = 1'b0; prev_valid = 1'b0; e = 0; accept_e = -1;
  endtask

  task automatic step_cycle();
    @(posedge clock);
    #1;
    e++;
    exp_strobe = 1'b0;
    if (pend_valid && (e % FRAME == 1)) begin
      model_frame(pend_key);
      pend_valid = 1'b0;
    end
    check_val("row_out", 32'(bus.row_out), 32'(1 << ((e / 4) % 4)));
    check_val("coder", 32'(bus.coder), (m_held < 0) ? 32'd63 : 32'(m_held));
    check_val("valid", 32'(bus.valid), (m_held < 0) ? 32'd0 : 32'd1);
    check_val("strobe", 32'(bus.strobe), 32'(exp_strobe));
    if (bus.strobe === 1'b1) strobe_seen++;
    if (bus.valid === 1'b1 && !prev_valid) accept_e = e;
    prev_valid = bus.valid;
    if (e % FRAME == 0) begin
      pend_key = lowest_key(keys);
      pend_valid = 1'b1;
    end
  endtask

  task automatic run_frames(input logic [19:0] k, input int n);
    keys = k;
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < FRAME; c++) step_cycle();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_row"}, 32'(bus.row_out), 32'd1);
    check_val({tag, "_coder"}, 32'(bus.coder), 32'd63);
    check_val({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check_val({tag, "_strobe"}, 32'(bus.strobe), 32'd0);
    check_val({tag, "_state"}, 32'(bus.state), 32'(IDLE));
  endtask

  logic [19:0] cur;

  initial begin
    keys = '0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Idle scanning, then key 7 held steadily.
    run_frames('0, 7);
    check_val("idle_no_strobe", 32'(strobe_seen), 32'd0);
    strobe_seen = 0;
    run_frames(20'd1 << 7, 14);
    check_val("k7_coder", 32'(bus.coder), 32'd7);
    check_val("k7_one_strobe", 32'(strobe_seen), 32'd1);
    run_frames('0, 4);

    // Interrupted press: 2 frames, gap, then 4 frames.
    strobe_seen = 0;
    run_frames(20'd1 << 7, 2);
    run_frames('0, 1);
    run_frames(20'd1 << 7, 4);
    check_val("k7_gap_one_strobe", 32'(strobe_seen), 32'd1);
    run_frames('0, 4);

    // Keys 3 and 12 together, then only 12.
    run_frames((20'd1 << 3) | (20'd1 << 12), 5);
    check_val("multi_lowest", 32'(bus.coder), 32'd3);
    strobe_seen = 0;
    run_frames(20'd1 << 12, 8);
    check_val("k12_coder", 32'(bus.coder), 32'd12);
    check_val("k12_new_strobe", 32'(strobe_seen), 32'd1);
    run_frames('0, 4);

    // Key 19 with a one-frame glitch, then a real release.
    strobe_seen = 0;
    run_frames(20'd1 << 19, 5);
    run_frames('0, 1);
    run_frames(20'd1 << 19, 3);
    check_val("k19_held", 32'(bus.coder), 32'd19);
    check_val("k19_one_strobe", 32'(strobe_seen), 32'd1);
    run_frames('0, 4);
    check_val("k19_released_valid", 32'(bus.valid), 32'd0);
    check_val("k19_released_coder", 32'(bus.coder), 32'd63);

    // Reset pulse while key 5 is accepted.
    run_frames(20'd1 << 5, 5);
    check_val("k5_pre_reset", 32'(bus.coder), 32'd5);
    for (int c = 0; c < 6; c++) step_cycle();
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    run_frames(20'd1 << 5, 5);
    check_val("k5_reaccept_edge", 32'(accept_e), 32'd49);

    // Random key sets, each held for a random number of whole frames.
    cur = '0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: cur = '0;
        1: cur = 20'd1 << $urandom_range(0, 19);
        2: cur = (20'd1 << $urandom_range(0, 19)) | (20'd1 << $urandom_range(0, 19));
        default: cur = cur;
      endcase
      run_frames(cur, $urandom_range(1, 4));
    end
    run_frames('0, 4);
    check_val("final_idle", 32'(bus.valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner_4x5.md
# keypad_scanner_4x5

Scans a 4-row by 5-column key matrix (20 keys), debounces the result and presents the pressed key as a 6-bit code with a valid flag and an accept strobe. It sits directly upstream of `decoder_6x20`: `coder` drives that decoder's 6-bit input, and the decoder lights one of its 20 outputs per key. Idle code 63 is outside the 0..19 key range, so downstream it decodes to all-zero.

## Interface
- `SCAN_CYCLES`, default 4: clocks each row is driven before its columns are sampled (minimum 2).
- `DEBOUNCE_SCANS`, default 3: consecutive matching frames required to accept a press or a release (minimum 1).
- `clock`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-high; one clock domain, async assert.
- `column_in`  input  5  matrix columns, active-high; bit c is column c; synchronous to `clock`.
- `row_out`  output  4  one-hot active-high row drive; bit r is row r.
- `coder`  output  6  held key index 0..19, or 6'd63 (KEY_NONE) when no key is held.
- `valid`  output  1  high while `coder` holds an accepted key.
- `strobe`  output  1  one-cycle pulse on the first cycle `valid` goes high for a new key.

## Operation
- Row scan: a dwell counter runs 0..SCAN_CYCLES-1 per row. At the terminal count the row advances 0→1→2→3→0 (wraps), one-hot.
- Sampling: `column_in` is captured on the terminal dwell cycle of each row. The earlier cycles are settling time.
- Frame: one frame is 4 rows. Within a frame the lowest pressed index wins, where index = row*5 + col, computed in 6 bits (maximum 19). If nothing is pressed the frame result is KEY_NONE. The frame result is evaluated once, at the end of row 3.
- FSM. States change only at frame end.
  - IDLE:
    - Result ≠ NONE → DEBOUNCE; candidate = result, count = 1.
    - If DEBOUNCE_SCANS = 1, go directly to PRESSED instead.
  - DEBOUNCE:
    - Result == candidate → count+1. When count reaches DEBOUNCE_SCANS → PRESSED.
    - Result is a different key → candidate = result, count = 1; stay in DEBOUNCE.
    - Result == NONE → IDLE.
  - PRESSED:
    - `coder` = held key, `valid` = 1. `strobe` pulses for one cycle on entry.
    - Result ≠ held key (NONE or another key) → RELEASE, count = 1.
  - RELEASE:
    - Result ≠ held key → count+1. When count reaches DEBOUNCE_SCANS → IDLE.
    - Result == held key → back to PRESSED with no new strobe.
- IDLE and DEBOUNCE: `coder` = 63, `valid` = 0. RELEASE keeps presenting the held key with `valid` = 1.
- A key held without break never generates a second strobe. A different key is reported only after the old key has been released through IDLE.
- Multiple simultaneous keys: the lowest index is reported. Releasing that key while the others stay down is treated as a key change (release path first).

## Timing
- Reset values: `row_out` = 4'b0001, dwell = 0, state IDLE, `coder` = 6'd63, `valid` = 0, `strobe` = 0, all counters 0.
- Reset asserted mid-operation returns every output to these values immediately. Scanning restarts at row 0 on the first clock after deassertion.
- Frame length = 4*SCAN_CYCLES clocks (16 with defaults).
- All outputs are registered and update on the clock after the frame-end evaluation.
- Press latency: from the first frame that sees the key, `valid`/`strobe` assert DEBOUNCE_SCANS frames later at that frame's end +1 clock. With defaults, a key stable from reset is accepted at clock 3*16 + 1 = 49.
- Release latency: DEBOUNCE_SCANS frames of absence. `coder` returns to 63 on the same clock that `valid` falls.

## Structure
- Package `keypad_pkg`:
  - KEY_NONE = 6'd63, ROWS = 4, COLS = 5.
  - State enum IDLE / DEBOUNCE / PRESSED / RELEASE.
  - Index function row*COLS + col.
- Sub-module `keypad_row_scanner`:
  - Contents: dwell counter, row one-hot rotation, column sampling and the lowest-index frame reduction.
  - Outputs: `frame_done` pulse and `frame_key[5:0]`.
- Top level holds the debounce FSM and the output registers.

## Test plan
All scenarios use the defaults (SCAN_CYCLES = 4, DEBOUNCE_SCANS = 3).
- Reset, no keys for 100 clocks → `row_out` cycles 0001, 0010, 0100, 1000 with 4 clocks each; `coder` = 63, `valid` = 0, `strobe` never pulses.
- Key 7 (row 1, col 2) held steadily → `coder` = 7, `valid` = 1 after 3 frames, a single 1-clock `strobe`, and no further strobes over 10 more frames.
- Key 7 present for 2 frames, absent for 1, present again → no acceptance until 3 consecutive frames; `strobe` pulses exactly once.
- Keys 3 and 12 both pressed → `coder` = 3. Release key 3 with key 12 still held → after 3 frames, IDLE (`coder` = 63), then key 12 is accepted 3 frames later with a new strobe.
- Accepted key 19 goes absent for 1 frame (glitch), then returns → stays in `valid` = 1 with `coder` = 19 and no strobe. Absent for 3 frames → `coder` = 63, `valid` = 0.
- `reset` pulsed while in PRESSED with key 5 → `coder` = 63, `valid` = 0 and `row_out` = 0001 immediately. After release of reset, key 5 is re-accepted after 3 full frames.
